// File: rtl/rr_grant_sched_pkg.sv
// Shared types and sizes for the sixteen-way round-robin grant scheduler.
package rr_grant_sched_pkg;

  localparam int NREQ = 16;
  localparam int IDXW = 4;
  localparam int CNTW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/rr_grant_sched_onehot_dec16.sv
// Combinational 4-to-16 one-hot decoder with enable; output is all zero when disabled.
module onehot_dec16
  import rr_grant_sched_pkg::*;
(
  input  logic [IDXW-1:0] i_idx,
  input  logic            i_en,
  output logic [NREQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_grant_sched.sv
// Sixteen-way round-robin grant scheduler with a mandatory dead cycle between owners.
// Optional per-owner hold limit is compiled in with RR_SCHED_HOLD_LIMIT_EN.
module rr_grant_sched
  import rr_grant_sched_pkg::*;
#(
  parameter int HOLD_MAX = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_rel,
  output logic [NREQ-1:0] o_gnt,
  output logic [IDXW-1:0] o_gnt_idx,
  output logic            o_gnt_vld
);

  state_t          r_state;
  state_t          w_next_state;
  logic [IDXW-1:0] r_ptr;
  logic [IDXW-1:0] r_gnt_idx;
  logic [CNTW-1:0] r_hold_cnt;
  logic            w_found;
  logic [IDXW-1:0] w_win;
  logic            w_load;
  logic            w_hold_hit;
  logic            w_grant_end;

  // Search starts one past the last owner, so the last owner has lowest priority.
  function automatic logic [IDXW:0] rrSearch(input logic [NREQ-1:0] req,
                                             input logic [IDXW-1:0] ptr);
    logic            found;
    logic [IDXW-1:0] idx;
    logic [IDXW-1:0] cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = ptr + k[IDXW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

  assign {w_found, w_win} = rrSearch(i_req, r_ptr);

`ifdef RR_SCHED_HOLD_LIMIT_EN
  assign w_hold_hit = (r_hold_cnt == CNTW'(HOLD_MAX - 1));
`else
  logic w_unused_hold;
  assign w_unused_hold = ^{r_hold_cnt, CNTW'(HOLD_MAX)};
  assign w_hold_hit    = 1'b0;
`endif

  assign w_grant_end = i_rel | ~i_req[r_gnt_idx] | w_hold_hit;

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      IDLE, GAP: begin
        if (w_found) begin
          w_next_state = GRANT;
          w_load       = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      GRANT: begin
        if (w_grant_end) begin
          w_next_state = GAP;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ptr      <= '1;
      r_gnt_idx  <= '0;
      r_hold_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_ptr      <= w_win;
        r_gnt_idx  <= w_win;
        r_hold_cnt <= '0;
      end else if (r_state == GRANT && r_hold_cnt != '1) begin
        r_hold_cnt <= r_hold_cnt + 1'b1;
      end
    end
  end

  assign o_gnt_vld = (r_state == GRANT);
  assign o_gnt_idx = r_gnt_idx;

  onehot_dec16 u_dec (
    .i_idx    (r_gnt_idx),
    .i_en     (o_gnt_vld),
    .o_onehot (o_gnt)
  );

endmodule

// File: tb/tb_rr_grant_sched.sv
// Scoreboard bench for rr_grant_sched: an abstract owner/priority model predicts each
// cycle's outputs, and a negedge monitor compares them against the DUT.
module tb_rr_grant_sched;

  localparam int HoldMax = 4;
`ifdef RR_SCHED_HOLD_LIMIT_EN
  localparam bit HoldLimitEn = 1'b1;
`else
  localparam bit HoldLimitEn = 1'b0;
`endif

  typedef struct packed {
    logic        vld;
    logic [15:0] gnt;
    logic [3:0]  idx;
  } expT;

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic [15:0] gnt;
  logic [3:0]  gntIdx;
  logic        gntVld;

  expT expQ[$];
  int  testCount = 0;
  int  failCount = 0;

  rr_grant_sched #(.HOLD_MAX(HoldMax)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_req     (req),
    .i_rel     (rel),
    .o_gnt     (gnt),
    .o_gnt_idx (gntIdx),
    .o_gnt_vld (gntVld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who owns the resource, how long they have held it, and where the next search begins.
  initial begin : refModel
    bit  granting;
    int  ownerIdx;
    int  searchFrom;
    int  held;
    bit  found;
    int  cand;
    expT e;
    granting   = 1'b0;
    ownerIdx   = 0;
    searchFrom = 0;
    held       = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        granting   = 1'b0;
        ownerIdx   = 0;
        searchFrom = 0;
        held       = 0;
      end else if (granting) begin
        held = held + 1;
        if (rel || !req[ownerIdx] || (HoldLimitEn && held >= HoldMax)) begin
          granting = 1'b0;
        end
      end else begin
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
          cand = (searchFrom + k) % 16;
          if (!found && req[cand]) begin
            found      = 1'b1;
            granting   = 1'b1;
            ownerIdx   = cand;
            searchFrom = (cand + 1) % 16;
            held       = 0;
          end
        end
      end
      e.vld = granting;
      e.gnt = granting ? (16'd1 << ownerIdx) : 16'd0;
      e.idx = 4'(ownerIdx);
      expQ.push_back(e);
    end
  end

  task automatic checkOutput(input expT e);
    testCount++;
    if (gntVld !== e.vld || gnt !== e.gnt || gntIdx !== e.idx) begin
      failCount++;
      $display("[TB] FAIL cycle_check t=%0t got vld=%b gnt=%h idx=%0d expected vld=%b gnt=%h idx=%0d",
               $time, gntVld, gnt, gntIdx, e.vld, e.gnt, e.idx);
    end
  endtask

  // Monitor: outputs are registered, so the negedge sample reflects the preceding posedge.
  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] r, input logic l, input logic s, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      req = r;
      rel = l;
      rst = s;
    end
  endtask

  initial begin : stimulus
    logic [15:0] rndReq;
    rst = 1'b1;
    req = '0;
    rel = 1'b0;
    applyStimulus(16'h0000, 1'b0, 1'b1, 2);
    applyStimulus(16'h0000, 1'b0, 1'b0, 10);

    for (int c = 0; c < 24; c++) begin
      applyStimulus(16'h0021, (c % 4) == 3, 1'b0, 1);
    end

    applyStimulus(16'h0000, 1'b0, 1'b1, 1);
    applyStimulus(16'h0080, 1'b0, 1'b0, 3);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 2);
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 1);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 3);
    applyStimulus(16'h8000, 1'b1, 1'b0, 1);
    applyStimulus(16'h8000, 1'b0, 1'b0, 3);
    applyStimulus(16'h0001, 1'b0, 1'b0, 4);

    applyStimulus(16'h0000, 1'b0, 1'b1, 1);
    applyStimulus(16'h0008, 1'b0, 1'b0, 20);
    applyStimulus(16'h0208, 1'b0, 1'b0, 2);
    applyStimulus(16'h0200, 1'b0, 1'b0, 4);

    applyStimulus(16'h1000, 1'b0, 1'b1, 1);
    applyStimulus(16'h1000, 1'b0, 1'b0, 3);
    applyStimulus(16'h1000, 1'b0, 1'b1, 1);
    applyStimulus(16'hFFFF, 1'b0, 1'b0, 4);
    applyStimulus(16'hFFFF, 1'b1, 1'b1, 1);
    applyStimulus(16'hFFFF, 1'b1, 1'b0, 2);

    rndReq = 16'($urandom);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7, 0) == 0) begin
        case ($urandom_range(3, 0))
          0:       rndReq = 16'($urandom);
          1:       rndReq = 16'($urandom) & 16'($urandom) & 16'($urandom);
          2:       rndReq = 16'd1 << $urandom_range(15, 0);
          default: rndReq = '0;
        endcase
      end
      applyStimulus(rndReq, $urandom_range(4, 0) == 0, $urandom_range(99, 0) == 0, 1);
    end

    applyStimulus(16'h0000, 1'b0, 1'b0, 3);
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
